iram_loader: RTL and testbench



---
 rtl/iram_loader.sv | 183 ++++++++++++++++++
 tb/tb_iram_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iram_loader.sv
// Byte-stream program loader: parses A5-framed bytes into 16-bit IRAM writes,
// holds the core in reset while loading and closes each frame with an XOR checksum.
module iram_loader #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned IRAM_ADDR_BITS = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [IRAM_ADDR_BITS-1:0] iram_wa,
    output logic                      iram_wen,
    output logic [WIDTH-1:0]          iram_din,
    output logic                      load_busy,
    output logic                      done,
    output logic                      err,
    output logic                      err_flag
);

    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [7:0]  HEADER = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_COUNT,
        S_LO,
        S_HI,
        S_CSUM
    } state_e;

    state_e                    state_q, state_d;
    logic [IRAM_ADDR_BITS-1:0] addr_q, addr_d;
    logic                      wen_q, wen_d;
    logic [WIDTH-1:0]          din_q, din_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      flag_q, flag_d;
    logic [7:0]                acc_q, acc_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [7:0]                lo_q, lo_d;
    logic [TMO_W-1:0]          tmo_q, tmo_d;
    logic                      timeout_c;

    // Terminal count; a byte arriving on the same cycle takes precedence.
    assign timeout_c = (state_q != S_IDLE) && !rx_valid
                       && (tmo_q >= TMO_W'(TIMEOUT_CYCLES - 2));

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wen_d   = 1'b0;
        din_d   = din_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        flag_d  = flag_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        tmo_d   = tmo_q;

        // Address advances the cycle after the write so wa is stable with wen.
        if (wen_q) begin
            addr_d = addr_q + IRAM_ADDR_BITS'(1);
        end

        // tmo_q holds cycles elapsed since the last byte; first cycle after a byte is 1.
        if (state_q != S_IDLE) begin
            tmo_d = rx_valid ? TMO_W'(1) : tmo_q + TMO_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_data == HEADER) begin
                    state_d = S_ADDR;
                    busy_d  = 1'b1;
                    flag_d  = 1'b0;
                    acc_d   = 8'h00;
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    addr_d  = rx_data[IRAM_ADDR_BITS-1:0];
                    acc_d   = acc_q ^ rx_data;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (rx_valid) begin
                    cnt_d   = rx_data;
                    acc_d   = acc_q ^ rx_data;
                    state_d = (rx_data == 8'h00) ? S_CSUM : S_LO;
                end
            end
            S_LO: begin
                if (rx_valid) begin
                    lo_d    = rx_data;
                    acc_d   = acc_q ^ rx_data;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (rx_valid) begin
                    wen_d   = 1'b1;
                    din_d   = WIDTH'({rx_data, lo_q});
                    acc_d   = acc_q ^ rx_data;
                    cnt_d   = cnt_q - 8'd1;
                    state_d = (cnt_q == 8'd1) ? S_CSUM : S_LO;
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == acc_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        flag_d = 1'b1;
                    end
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (timeout_c) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            flag_d  = 1'b1;
        end

        if (state_d == S_IDLE) begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            flag_q  <= 1'b0;
            acc_q   <= 8'h00;
            cnt_q   <= 8'h00;
            lo_q    <= 8'h00;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            flag_q  <= flag_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            tmo_q   <= tmo_d;
        end
    end

    assign iram_wa   = addr_q;
    assign iram_wen  = wen_q;
    assign iram_din  = din_q;
    assign load_busy = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_flag  = flag_q;

endmodule

// File: tb/tb_iram_loader.sv
// Scoreboard bench for iram_loader: expected writes and done/err events are queued
// as bytes are sent and checked by a monitor as the DUT produces them.
module tb_iram_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  iram_wa;
    logic        iram_wen;
    logic [15:0] iram_din;
    logic        load_busy;
    logic        done;
    logic        err;
    logic        err_flag;

    int checks = 0;
    int errors = 0;

    logic [23:0] wr_q[$];   // {addr, data}
    int          ev_q[$];   // 1 = done, 2 = err

    iram_loader #(
        .WIDTH(16),
        .IRAM_ADDR_BITS(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .iram_wa(iram_wa),
        .iram_wen(iram_wen),
        .iram_din(iram_din),
        .load_busy(load_busy),
        .done(done),
        .err(err),
        .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    // Called at posedge+1; consecutive calls give back-to-back strobes.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic monitor();
        logic [23:0] exp_wr;
        int          exp_ev;
        int          got_ev;
        logic        prev_wen;
        prev_wen = 1'b0;
        forever begin
            @(negedge clk);
            if (iram_wen) begin
                checks++;
                if (prev_wen) begin
                    errors++;
                    $display("FAIL wen_width: got wen high two cycles, required one-cycle pulse");
                end
                if (!load_busy) begin
                    errors++;
                    $display("FAIL busy_during_write: got load_busy=0, required 1");
                end
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got wa=%h din=%h, required no write", iram_wa, iram_din);
                end else begin
                    exp_wr = wr_q.pop_front();
                    if ({iram_wa, iram_din} !== exp_wr) begin
                        errors++;
                        $display("FAIL write: got wa=%h din=%h, required wa=%h din=%h",
                                 iram_wa, iram_din, exp_wr[23:16], exp_wr[15:0]);
                    end
                end
            end
            if (done || err) begin
                checks++;
                got_ev = done ? 1 : 2;
                if (done && err) begin
                    errors++;
                    $display("FAIL done_err_overlap: got done=1 err=1, required exclusive");
                end else if (load_busy) begin
                    errors++;
                    $display("FAIL busy_fall: got load_busy=1 with done/err, required 0");
                end else if (ev_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got event %0d, required none", got_ev);
                end else begin
                    exp_ev = ev_q.pop_front();
                    if (got_ev !== exp_ev) begin
                        errors++;
                        $display("FAIL event: got %0d, required %0d (1=done 2=err)", got_ev, exp_ev);
                    end
                end
            end
            prev_wen = iram_wen;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((wr_q.size() != 0 || ev_q.size() != 0) && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (wr_q.size() != 0 || ev_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d writes %0d events outstanding, required 0",
                     name, wr_q.size(), ev_q.size());
            wr_q.delete();
            ev_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({iram_wa, iram_wen, iram_din, load_busy, done, err, err_flag} !== 29'd0) begin
            errors++;
            $display("FAIL %s: got wa=%h wen=%b din=%h busy=%b done=%b err=%b flag=%b, required all 0",
                     name, iram_wa, iram_wen, iram_din, load_busy, done, err, err_flag);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;
    endtask

    task automatic test_good_frame();
        wr_q.push_back({8'h10, 16'h1234});
        wr_q.push_back({8'h11, 16'h5678});
        send_byte(8'hA5);
        checks++;
        if (load_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise: got %b, required 1", load_busy);
        end
        send_byte(8'h10);
        send_byte(8'h02);
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'h78);
        send_byte(8'h56);
        ev_q.push_back(1);
        send_byte(8'h1A);
        drain("good_frame");
        checks++;
        if (err_flag !== 1'b0 || iram_wa !== 8'h12) begin
            errors++;
            $display("FAIL good_frame_after: got flag=%b wa=%h, required flag=0 wa=12", err_flag, iram_wa);
        end
    endtask

    task automatic test_bad_csum();
        wr_q.push_back({8'h10, 16'h1234});
        wr_q.push_back({8'h11, 16'h5678});
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h02);
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'h78);
        send_byte(8'h56);
        ev_q.push_back(2);
        send_byte(8'h1B);
        drain("bad_csum");
        checks++;
        if (err_flag !== 1'b1) begin
            errors++;
            $display("FAIL bad_csum_flag: got %b, required 1", err_flag);
        end
        send_byte(8'hA5);
        checks++;
        if (err_flag !== 1'b0) begin
            errors++;
            $display("FAIL flag_clear: got %b, required 0", err_flag);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        ev_q.push_back(1);
        send_byte(8'h00);
        drain("flag_clear");
    endtask

    task automatic test_wrap();
        logic [7:0] frame [8];
        frame = '{8'hA5, 8'hFF, 8'h02, 8'h01, 8'h00, 8'h02, 8'h00, 8'hFE};
        wr_q.push_back({8'hFF, 16'h0001});
        wr_q.push_back({8'h00, 16'h0002});
        for (int i = 0; i < 8; i++) begin
            if (i == 7) ev_q.push_back(1);
            send_byte(frame[i]);
        end
        drain("wrap");
    endtask

    task automatic test_garbage();
        logic [7:0] bytes [6];
        bytes = '{8'h00, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) begin
            if (i == 5) ev_q.push_back(1);
            send_byte(bytes[i]);
            idle(1);
        end
        drain("garbage");
    endtask

    task automatic test_timeout();
        int first_err;
        send_byte(8'hA5);
        send_byte(8'h20);
        send_byte(8'h01);
        ev_q.push_back(2);
        send_byte(8'hAA);
        first_err = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (err && first_err < 0) first_err = k;
        end
        checks++;
        if (first_err != 15) begin
            errors++;
            $display("FAIL timeout_latency: got err at %0d cycles, required 15", first_err);
        end
        checks++;
        if (load_busy !== 1'b0 || err_flag !== 1'b1) begin
            errors++;
            $display("FAIL timeout_state: got busy=%b flag=%b, required busy=0 flag=1", load_busy, err_flag);
        end
        @(posedge clk);
        #1;
        drain("timeout");
    endtask

    task automatic test_terminal_byte();
        send_byte(8'hA5);
        send_byte(8'h20);
        send_byte(8'h01);
        send_byte(8'hAA);
        idle(13);
        wr_q.push_back({8'h20, 16'hBBAA});
        send_byte(8'hBB);
        idle(3);
        checks++;
        if (load_busy !== 1'b1) begin
            errors++;
            $display("FAIL terminal_byte_busy: got %b, required 1", load_busy);
        end
        ev_q.push_back(1);
        send_byte(8'h30);
        drain("terminal_byte");
    endtask

    task automatic test_rst_midframe();
        send_byte(8'hA5);
        send_byte(8'h30);
        send_byte(8'h01);
        send_byte(8'h44);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("rst_midframe");
        @(posedge clk);
        #1;
        send_byte(8'h55);
        idle(4);
        checks++;
        if (load_busy !== 1'b0 || iram_wa !== 8'h00) begin
            errors++;
            $display("FAIL rst_hi_ignored: got busy=%b wa=%h, required busy=0 wa=00", load_busy, iram_wa);
        end
        drain("rst_midframe");
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_wrap();
        test_garbage();
        test_timeout();
        test_terminal_byte();
        test_rst_midframe();
        idle(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
